// File: rtl/ct_lsu_pfu_gpfb_mlvl_if.sv
// Global prefetch buffer bundle: GSDB/LD-DA/CP0 controls and BIU/MMU arbiter handshakes.
// The slave modport is the prefetch buffer; the master modport is its environment.
interface ct_lsu_pfu_gpfb_mlvl_if #(
    parameter int VA_W     = 40,
    parameter int PPN_W    = 28,
    parameter int PGOFF_W  = 12,
    parameter int STRIDE_W = 11,
    parameter int DIST_W   = 4
);
    logic                       cp0_lsu_pfu_mmu_dis;
    logic [1:0]                 cp0_yy_priv_mode;
    logic                       pfu_gsdb_gpfb_create_vld;
    logic                       pfu_gsdb_gpfb_pop_req;
    logic                       pfu_pop_all_vld;
    logic [STRIDE_W-1:0]        pfu_gsdb_stride;
    logic                       pfu_gsdb_stride_neg;
    logic [VA_W-1:0]            ld_da_pfu_va;
    logic [PPN_W-1:0]           ld_da_ppn_ff;
    logic                       ld_da_page_sec_ff;
    logic                       ld_da_page_share_ff;
    logic                       ld_da_pfu_act_vld;
    logic [DIST_W-1:0]          lsu_pfu_l1_dist_sel;
    logic [DIST_W-1:0]          lsu_pfu_l2_dist_sel;
    logic                       pfu_dcache_pref_en;
    logic                       pfu_l2_pref_en;
    logic                       pfu_gpfb_biu_pe_req_grnt;
    logic                       pfu_biu_pe_req_sel_l1;
    logic                       pfu_gpfb_mmu_pe_req_grnt;
    logic                       pfu_mmu_pe_req_sel_l1;
    logic                       pfu_get_ppn_vld;
    logic                       pfu_get_ppn_err;
    logic [PPN_W-1:0]           pfu_get_ppn;
    logic                       pfu_get_page_sec;
    logic                       pfu_get_page_share;

    logic                       pfu_gpfb_vld;
    logic [1:0]                 pfu_gpfb_priv_mode;
    logic                       pfu_gpfb_biu_pe_req;
    logic [1:0]                 pfu_gpfb_biu_pe_req_src;
    logic                       pfu_gpfb_mmu_pe_req;
    logic [1:0]                 pfu_gpfb_mmu_pe_req_src;
    logic [PPN_W+PGOFF_W-1:0]   pfu_gpfb_l1_pf_addr;
    logic [PPN_W+PGOFF_W-1:0]   pfu_gpfb_l2_pf_addr;
    logic [VA_W-PGOFF_W-1:0]    pfu_gpfb_l1_vpn;
    logic [VA_W-PGOFF_W-1:0]    pfu_gpfb_l2_vpn;
    logic                       pfu_gpfb_l1_page_sec;
    logic                       pfu_gpfb_l1_page_share;
    logic                       pfu_gpfb_l2_page_sec;
    logic                       pfu_gpfb_l2_page_share;

    modport slave (
        input  cp0_lsu_pfu_mmu_dis, cp0_yy_priv_mode, pfu_gsdb_gpfb_create_vld,
               pfu_gsdb_gpfb_pop_req, pfu_pop_all_vld, pfu_gsdb_stride, pfu_gsdb_stride_neg,
               ld_da_pfu_va, ld_da_ppn_ff, ld_da_page_sec_ff, ld_da_page_share_ff,
               ld_da_pfu_act_vld, lsu_pfu_l1_dist_sel, lsu_pfu_l2_dist_sel,
               pfu_dcache_pref_en, pfu_l2_pref_en, pfu_gpfb_biu_pe_req_grnt,
               pfu_biu_pe_req_sel_l1, pfu_gpfb_mmu_pe_req_grnt, pfu_mmu_pe_req_sel_l1,
               pfu_get_ppn_vld, pfu_get_ppn_err, pfu_get_ppn, pfu_get_page_sec,
               pfu_get_page_share,
        output pfu_gpfb_vld, pfu_gpfb_priv_mode, pfu_gpfb_biu_pe_req, pfu_gpfb_biu_pe_req_src,
               pfu_gpfb_mmu_pe_req, pfu_gpfb_mmu_pe_req_src, pfu_gpfb_l1_pf_addr,
               pfu_gpfb_l2_pf_addr, pfu_gpfb_l1_vpn, pfu_gpfb_l2_vpn, pfu_gpfb_l1_page_sec,
               pfu_gpfb_l1_page_share, pfu_gpfb_l2_page_sec, pfu_gpfb_l2_page_share
    );

    modport master (
        output cp0_lsu_pfu_mmu_dis, cp0_yy_priv_mode, pfu_gsdb_gpfb_create_vld,
               pfu_gsdb_gpfb_pop_req, pfu_pop_all_vld, pfu_gsdb_stride, pfu_gsdb_stride_neg,
               ld_da_pfu_va, ld_da_ppn_ff, ld_da_page_sec_ff, ld_da_page_share_ff,
               ld_da_pfu_act_vld, lsu_pfu_l1_dist_sel, lsu_pfu_l2_dist_sel,
               pfu_dcache_pref_en, pfu_l2_pref_en, pfu_gpfb_biu_pe_req_grnt,
               pfu_biu_pe_req_sel_l1, pfu_gpfb_mmu_pe_req_grnt, pfu_mmu_pe_req_sel_l1,
               pfu_get_ppn_vld, pfu_get_ppn_err, pfu_get_ppn, pfu_get_page_sec,
               pfu_get_page_share,
        input  pfu_gpfb_vld, pfu_gpfb_priv_mode, pfu_gpfb_biu_pe_req, pfu_gpfb_biu_pe_req_src,
               pfu_gpfb_mmu_pe_req, pfu_gpfb_mmu_pe_req_src, pfu_gpfb_l1_pf_addr,
               pfu_gpfb_l2_pf_addr, pfu_gpfb_l1_vpn, pfu_gpfb_l2_vpn, pfu_gpfb_l1_page_sec,
               pfu_gpfb_l1_page_share, pfu_gpfb_l2_page_sec, pfu_gpfb_l2_page_share
    );
endinterface

// File: rtl/ct_lsu_pfu_gpfb_mlvl.sv
// Global prefetch buffer: one stride stream with independent L1/L2 issue pointers that run
// ahead of demand loads by a programmable distance, requesting translation on page cross.
module ct_lsu_pfu_gpfb_mlvl #(
    parameter int VA_W     = 40,
    parameter int PPN_W    = 28,
    parameter int PGOFF_W  = 12,
    parameter int STRIDE_W = 11,
    parameter int DIST_W   = 4
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    ct_lsu_pfu_gpfb_mlvl_if.slave    bus
);
    localparam logic [1:0] ST_INV   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_TLB   = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Entry-level state
    logic               r_vld;
    logic [1:0]         r_priv;
    logic               r_first_l1;   // with both levels in WAIT, L1 was granted first

    // Per-level views (index 0 = L1, 1 = L2)
    logic [1:0]         w_st   [2];
    logic [VA_W-1:0]    w_ptr  [2];
    logic [PPN_W-1:0]   w_ppn  [2];
    logic [1:0]         w_sec;
    logic [1:0]         w_share;
    logic [1:0]         w_en;
    logic [DIST_W-1:0]  w_sel  [2];
    logic [1:0]         w_biu_pick;
    logic [1:0]         w_mmu_pick;
    logic [1:0]         w_biu_src;
    logic [1:0]         w_mmu_src;
    logic [1:0]         w_biu_gnt;
    logic [1:0]         w_mmu_gnt;
    logic [1:0]         w_wait;
    logic [1:0]         w_ret;
    logic [1:0]         w_lvl_kill;

    logic [VA_W-1:0]    w_stride_ext;
    logic [VA_W-1:0]    w_cr_ptr;
    logic               w_cr_cross;
    logic               w_kill;
    logic               w_clear;

    assign w_en[0]       = bus.pfu_dcache_pref_en;
    assign w_en[1]       = bus.pfu_l2_pref_en;
    assign w_sel[0]      = bus.lsu_pfu_l1_dist_sel;
    assign w_sel[1]      = bus.lsu_pfu_l2_dist_sel;
    assign w_biu_pick[0] = bus.pfu_biu_pe_req_sel_l1;
    assign w_biu_pick[1] = !bus.pfu_biu_pe_req_sel_l1;
    assign w_mmu_pick[0] = bus.pfu_mmu_pe_req_sel_l1;
    assign w_mmu_pick[1] = !bus.pfu_mmu_pe_req_sel_l1;

    assign w_stride_ext = {{(VA_W-STRIDE_W){1'b0}}, bus.pfu_gsdb_stride};
    assign w_cr_ptr     = bus.pfu_gsdb_stride_neg ? (bus.ld_da_pfu_va - w_stride_ext)
                                                  : (bus.ld_da_pfu_va + w_stride_ext);
    assign w_cr_cross   = w_cr_ptr[VA_W-1:PGOFF_W] != bus.ld_da_pfu_va[VA_W-1:PGOFF_W];

    assign w_kill  = r_vld && ((bus.cp0_yy_priv_mode != r_priv) || (|w_lvl_kill));
    // pop_all beats create, create beats pop_req and internal kills
    assign w_clear = bus.pfu_pop_all_vld ||
                     (!bus.pfu_gsdb_gpfb_create_vld && (bus.pfu_gsdb_gpfb_pop_req || w_kill));

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lvl
            localparam int   OTHER = 1 - g;
            localparam logic IS_L1 = (g == 0);

            logic [1:0]         r_st;
            logic [VA_W-1:0]    r_ptr;
            logic [PPN_W-1:0]   r_ppn;
            logic               r_sec;
            logic               r_share;
            logic [DIST_W:0]    r_ahead;
            logic [VA_W-1:0]    w_next;
            logic               w_cross;
            logic [DIST_W:0]    w_lim;

            assign w_st[g]    = r_st;
            assign w_ptr[g]   = r_ptr;
            assign w_ppn[g]   = r_ppn;
            assign w_sec[g]   = r_sec;
            assign w_share[g] = r_share;

            assign w_next  = bus.pfu_gsdb_stride_neg ? (r_ptr - w_stride_ext) : (r_ptr + w_stride_ext);
            assign w_cross = w_next[VA_W-1:PGOFF_W] != r_ptr[VA_W-1:PGOFF_W];
            assign w_lim   = {1'b0, w_sel[g]} + {{DIST_W{1'b0}}, 1'b1};

            assign w_biu_src[g] = r_vld && (r_st == ST_ISSUE) && w_en[g] && (r_ahead < w_lim);
            assign w_biu_gnt[g] = bus.pfu_gpfb_biu_pe_req_grnt && w_biu_pick[g] && w_biu_src[g];
            assign w_mmu_src[g] = r_vld && (r_st == ST_TLB) && !bus.cp0_lsu_pfu_mmu_dis;
            assign w_mmu_gnt[g] = bus.pfu_gpfb_mmu_pe_req_grnt && w_mmu_pick[g] && w_mmu_src[g];
            assign w_wait[g]    = (r_st == ST_WAIT);
            // Translations return in grant order: with both waiting, the older grant owns it
            assign w_ret[g]     = w_wait[g] && (!w_wait[OTHER] || (r_first_l1 == IS_L1));
            assign w_lvl_kill[g] = (w_ret[g] && bus.pfu_get_ppn_err) ||
                                   (w_biu_gnt[g] && w_cross && bus.cp0_lsu_pfu_mmu_dis) ||
                                   ((r_st == ST_TLB) && bus.cp0_lsu_pfu_mmu_dis);

            // Level FSM, issue pointer, translation and ahead-credit tracking
            always_ff @(posedge forever_cpuclk) begin
                if (cpurst || w_clear) begin
                    r_st    <= ST_INV;
                    r_ptr   <= '0;
                    r_ppn   <= '0;
                    r_sec   <= 1'b0;
                    r_share <= 1'b0;
                    r_ahead <= '0;
                end else if (bus.pfu_gsdb_gpfb_create_vld) begin
                    r_st    <= w_cr_cross ? ST_TLB : ST_ISSUE;
                    r_ptr   <= w_cr_ptr;
                    r_ppn   <= bus.ld_da_ppn_ff;
                    r_sec   <= bus.ld_da_page_sec_ff;
                    r_share <= bus.ld_da_page_share_ff;
                    r_ahead <= '0;
                end else begin
                    case (r_st)
                        ST_ISSUE: begin
                            if (w_biu_gnt[g]) begin
                                r_ptr <= w_next;
                                if (w_cross) begin
                                    r_st <= ST_TLB;
                                end
                            end
                        end
                        ST_TLB: begin
                            if (w_mmu_gnt[g]) begin
                                r_st <= ST_WAIT;
                            end
                        end
                        ST_WAIT: begin
                            if (w_ret[g] && bus.pfu_get_ppn_vld && !bus.pfu_get_ppn_err) begin
                                r_ppn   <= bus.pfu_get_ppn;
                                r_sec   <= bus.pfu_get_page_sec;
                                r_share <= bus.pfu_get_page_share;
                                r_st    <= ST_ISSUE;
                            end
                        end
                        default: ;
                    endcase
                    // Grant and demand in the same cycle cancel out
                    if (w_biu_gnt[g] && !bus.ld_da_pfu_act_vld) begin
                        r_ahead <= r_ahead + 1'b1;
                    end else if (!w_biu_gnt[g] && bus.ld_da_pfu_act_vld && (r_ahead != '0)) begin
                        r_ahead <= r_ahead - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Entry valid, captured privilege and MMU grant ordering
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || w_clear) begin
            r_vld      <= 1'b0;
            r_priv     <= '0;
            r_first_l1 <= 1'b0;
        end else if (bus.pfu_gsdb_gpfb_create_vld) begin
            r_vld      <= 1'b1;
            r_priv     <= bus.cp0_yy_priv_mode;
            r_first_l1 <= 1'b0;
        end else if (w_mmu_gnt[0]) begin
            r_first_l1 <= !w_wait[1];
        end else if (w_mmu_gnt[1]) begin
            r_first_l1 <= w_wait[0];
        end
    end

    assign bus.pfu_gpfb_vld            = r_vld;
    assign bus.pfu_gpfb_priv_mode      = r_priv;
    assign bus.pfu_gpfb_biu_pe_req_src = w_biu_src;
    assign bus.pfu_gpfb_biu_pe_req     = |w_biu_src;
    assign bus.pfu_gpfb_mmu_pe_req_src = w_mmu_src;
    assign bus.pfu_gpfb_mmu_pe_req     = |w_mmu_src;
    assign bus.pfu_gpfb_l1_pf_addr     = {w_ppn[0], w_ptr[0][PGOFF_W-1:0]};
    assign bus.pfu_gpfb_l2_pf_addr     = {w_ppn[1], w_ptr[1][PGOFF_W-1:0]};
    assign bus.pfu_gpfb_l1_vpn         = w_ptr[0][VA_W-1:PGOFF_W];
    assign bus.pfu_gpfb_l2_vpn         = w_ptr[1][VA_W-1:PGOFF_W];
    assign bus.pfu_gpfb_l1_page_sec    = w_sec[0];
    assign bus.pfu_gpfb_l1_page_share  = w_share[0];
    assign bus.pfu_gpfb_l2_page_sec    = w_sec[1];
    assign bus.pfu_gpfb_l2_page_share  = w_share[1];
endmodule

// File: tb/tb_ct_lsu_pfu_gpfb_mlvl.sv
// Directed bench for the global prefetch buffer: issue/ahead limits, page-cross translation,
// invalidation sources and priorities, with hand-computed expected values.
module tb_ct_lsu_pfu_gpfb_mlvl;
    logic clk = 1'b0;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    ct_lsu_pfu_gpfb_mlvl_if #(.VA_W(40), .PPN_W(28), .PGOFF_W(12), .STRIDE_W(11), .DIST_W(4)) bus_if();

    ct_lsu_pfu_gpfb_mlvl #(.VA_W(40), .PPN_W(28), .PGOFF_W(12), .STRIDE_W(11), .DIST_W(4)) u_dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic create(input logic [39:0] va, input logic neg, input logic [27:0] ppn);
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b1;
        bus_if.ld_da_pfu_va             = va;
        bus_if.pfu_gsdb_stride_neg      = neg;
        bus_if.ld_da_ppn_ff             = ppn;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.cp0_lsu_pfu_mmu_dis      = 1'b0;
        bus_if.cp0_yy_priv_mode         = 2'd3;
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        bus_if.pfu_gsdb_gpfb_pop_req    = 1'b0;
        bus_if.pfu_pop_all_vld          = 1'b0;
        bus_if.pfu_gsdb_stride          = 11'h040;
        bus_if.pfu_gsdb_stride_neg      = 1'b0;
        bus_if.ld_da_pfu_va             = '0;
        bus_if.ld_da_ppn_ff             = '0;
        bus_if.ld_da_page_sec_ff        = 1'b1;
        bus_if.ld_da_page_share_ff      = 1'b0;
        bus_if.ld_da_pfu_act_vld        = 1'b0;
        bus_if.lsu_pfu_l1_dist_sel      = 4'd1;
        bus_if.lsu_pfu_l2_dist_sel      = 4'd3;
        bus_if.pfu_dcache_pref_en       = 1'b1;
        bus_if.pfu_l2_pref_en           = 1'b1;
        bus_if.pfu_gpfb_biu_pe_req_grnt = 1'b0;
        bus_if.pfu_biu_pe_req_sel_l1    = 1'b1;
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b0;
        bus_if.pfu_mmu_pe_req_sel_l1    = 1'b1;
        bus_if.pfu_get_ppn_vld          = 1'b0;
        bus_if.pfu_get_ppn_err          = 1'b0;
        bus_if.pfu_get_ppn              = '0;
        bus_if.pfu_get_page_sec         = 1'b0;
        bus_if.pfu_get_page_share       = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_vld",  64'(bus_if.pfu_gpfb_vld), 64'd0);
        chk("rst_biu",  64'(bus_if.pfu_gpfb_biu_pe_req), 64'd0);
        chk("rst_mmu",  64'(bus_if.pfu_gpfb_mmu_pe_req), 64'd0);
        chk("rst_addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'd0);
        chk("rst_priv", 64'(bus_if.pfu_gpfb_priv_mode), 64'd0);

        // Positive stride create: both pointers at 0x1040 in the same page
        create(40'h1000, 1'b0, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("cr_vld",    64'(bus_if.pfu_gpfb_vld), 64'd1);
        chk("cr_priv",   64'(bus_if.pfu_gpfb_priv_mode), 64'd3);
        chk("cr_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h3);
        chk("cr_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h123040);
        chk("cr_l2addr", 64'(bus_if.pfu_gpfb_l2_pf_addr), 64'h123040);
        chk("cr_l1vpn",  64'(bus_if.pfu_gpfb_l1_vpn), 64'h1);
        chk("cr_l1sec",  64'(bus_if.pfu_gpfb_l1_page_sec), 64'd1);
        chk("cr_mmu",    64'(bus_if.pfu_gpfb_mmu_pe_req), 64'd0);

        // Level enable gates the request combinationally
        bus_if.pfu_dcache_pref_en = 1'b0;
        #1;
        chk("en_off_src", 64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h2);
        bus_if.pfu_dcache_pref_en = 1'b1;
        #1;

        // Two L1 grants reach the sel+1 = 2 ahead limit
        bus_if.pfu_gpfb_biu_pe_req_grnt = 1'b1;
        bus_if.pfu_biu_pe_req_sel_l1    = 1'b1;
        tick();
        chk("g1_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h123080);
        chk("g1_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h3);
        chk("g1_l2addr", 64'(bus_if.pfu_gpfb_l2_pf_addr), 64'h123040);
        tick();
        chk("g2_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h1230C0);
        chk("g2_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h2);
        // Grant to a non-requesting L1 is ignored
        tick();
        bus_if.pfu_gpfb_biu_pe_req_grnt = 1'b0;
        chk("gign_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h1230C0);
        chk("gign_l2addr", 64'(bus_if.pfu_gpfb_l2_pf_addr), 64'h123040);

        // Demand load frees one credit
        bus_if.ld_da_pfu_act_vld = 1'b1;
        tick();
        bus_if.ld_da_pfu_act_vld = 1'b0;
        chk("act_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h3);
        chk("act_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h1230C0);

        // Grant and demand together leave the credit count unchanged (stays 1)
        bus_if.ld_da_pfu_act_vld        = 1'b1;
        bus_if.pfu_gpfb_biu_pe_req_grnt = 1'b1;
        tick();
        bus_if.ld_da_pfu_act_vld = 1'b0;
        chk("gd_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h3);
        chk("gd_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h123100);
        tick();
        bus_if.pfu_gpfb_biu_pe_req_grnt = 1'b0;
        chk("gd2_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h2);
        chk("gd2_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h123140);

        // Negative stride reload: 0x1000-0x40 = 0x0FC0 crosses into page 0
        create(40'h1000, 1'b1, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("neg_vld",    64'(bus_if.pfu_gpfb_vld), 64'd1);
        chk("neg_biu",    64'(bus_if.pfu_gpfb_biu_pe_req), 64'd0);
        chk("neg_mmusrc", 64'(bus_if.pfu_gpfb_mmu_pe_req_src), 64'h3);
        chk("neg_l1vpn",  64'(bus_if.pfu_gpfb_l1_vpn), 64'h0);
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b1;
        bus_if.pfu_mmu_pe_req_sel_l1    = 1'b1;
        tick();
        chk("mg1_src", 64'(bus_if.pfu_gpfb_mmu_pe_req_src), 64'h2);
        bus_if.pfu_mmu_pe_req_sel_l1 = 1'b0;
        tick();
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b0;
        chk("mg2_src", 64'(bus_if.pfu_gpfb_mmu_pe_req_src), 64'h0);
        // First return belongs to L1 (granted first)
        bus_if.pfu_get_ppn_vld    = 1'b1;
        bus_if.pfu_get_ppn        = 28'h55;
        bus_if.pfu_get_page_share = 1'b1;
        tick();
        chk("ret1_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h55FC0);
        chk("ret1_share",  64'(bus_if.pfu_gpfb_l1_page_share), 64'd1);
        chk("ret1_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h1);
        bus_if.pfu_get_ppn        = 28'h66;
        bus_if.pfu_get_page_share = 1'b0;
        tick();
        chk("ret2_l2addr", 64'(bus_if.pfu_gpfb_l2_pf_addr), 64'h66FC0);
        chk("ret2_src",    64'(bus_if.pfu_gpfb_biu_pe_req_src), 64'h3);
        // Return with nothing waiting is dropped
        bus_if.pfu_get_ppn = 28'h77;
        tick();
        bus_if.pfu_get_ppn_vld = 1'b0;
        chk("ret3_l1addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h55FC0);

        // Translation error kills the entry
        create(40'h1000, 1'b1, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b1;
        bus_if.pfu_mmu_pe_req_sel_l1    = 1'b1;
        tick();
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b0;
        bus_if.pfu_get_ppn_err          = 1'b1;
        tick();
        bus_if.pfu_get_ppn_err = 1'b0;
        chk("err_vld", 64'(bus_if.pfu_gpfb_vld), 64'd0);
        chk("err_biu", 64'(bus_if.pfu_gpfb_biu_pe_req), 64'd0);
        chk("err_mmu", 64'(bus_if.pfu_gpfb_mmu_pe_req), 64'd0);

        // MMU disabled: page-crossing entry raises no MMU request and dies
        bus_if.cp0_lsu_pfu_mmu_dis = 1'b1;
        create(40'h1000, 1'b1, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("mdis_vld1", 64'(bus_if.pfu_gpfb_vld), 64'd1);
        chk("mdis_mmu",  64'(bus_if.pfu_gpfb_mmu_pe_req), 64'd0);
        tick();
        chk("mdis_vld2", 64'(bus_if.pfu_gpfb_vld), 64'd0);
        bus_if.cp0_lsu_pfu_mmu_dis = 1'b0;

        // pop_all beats create
        create(40'h1000, 1'b0, 28'h123);
        tick();
        bus_if.pfu_pop_all_vld = 1'b1;
        tick();
        bus_if.pfu_pop_all_vld          = 1'b0;
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("popall_vld", 64'(bus_if.pfu_gpfb_vld), 64'd0);
        // create beats pop_req and reloads
        create(40'h2000, 1'b0, 28'h124);
        tick();
        create(40'h3000, 1'b0, 28'h125);
        bus_if.pfu_gsdb_gpfb_pop_req = 1'b1;
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("crpop_vld",  64'(bus_if.pfu_gpfb_vld), 64'd1);
        chk("crpop_addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'h125040);
        chk("crpop_vpn",  64'(bus_if.pfu_gpfb_l1_vpn), 64'h3);
        tick();
        bus_if.pfu_gsdb_gpfb_pop_req = 1'b0;
        chk("pop_vld", 64'(bus_if.pfu_gpfb_vld), 64'd0);

        // Privilege change kills the entry
        create(40'h1000, 1'b0, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        chk("priv_vld1", 64'(bus_if.pfu_gpfb_vld), 64'd1);
        bus_if.cp0_yy_priv_mode = 2'd1;
        tick();
        chk("priv_vld2", 64'(bus_if.pfu_gpfb_vld), 64'd0);
        bus_if.cp0_yy_priv_mode = 2'd3;

        // Reset while waiting for translation; a late return is ignored
        create(40'h1000, 1'b1, 28'h123);
        tick();
        bus_if.pfu_gsdb_gpfb_create_vld = 1'b0;
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b1;
        tick();
        bus_if.pfu_gpfb_mmu_pe_req_grnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_vld",  64'(bus_if.pfu_gpfb_vld), 64'd0);
        chk("rw_mmu",  64'(bus_if.pfu_gpfb_mmu_pe_req), 64'd0);
        chk("rw_addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'd0);
        bus_if.pfu_get_ppn_vld = 1'b1;
        bus_if.pfu_get_ppn     = 28'h99;
        tick();
        bus_if.pfu_get_ppn_vld = 1'b0;
        chk("late_vld",  64'(bus_if.pfu_gpfb_vld), 64'd0);
        chk("late_addr", 64'(bus_if.pfu_gpfb_l1_pf_addr), 64'd0);
        chk("late_biu",  64'(bus_if.pfu_gpfb_biu_pe_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
